// File: rtl/pulse_train_receiver_if.sv
// ----------------------------------------------------------------------------
// pulse_train_receiver_if
//   Bundles the pulse line, the enable and the measurement results of the
//   pulse train receiver.
//   master : stimulus side, drives signal/on and observes the results
//   slave  : receiver side, samples signal/on and drives the results
//   signal       pulse line (asynchronous to the receiver clock)
//   on           receiver enable
//   pulse_valid  1-cycle strobe, legal pulse accepted
//   pulse_width  width of the last measured pulse, in cycles
//   pulse_error  1-cycle strobe, pulse outside the legal window
//   burst_done   1-cycle strobe, burst closed by the idle timeout
//   burst_count  legal pulses in the last closed burst
// ----------------------------------------------------------------------------
interface pulse_train_receiver_if #(
    parameter int WIDTH_BITS = 8,
    parameter int COUNT_BITS = 4
);
    logic                  signal;
    logic                  on;
    logic                  pulse_valid;
    logic [WIDTH_BITS-1:0] pulse_width;
    logic                  pulse_error;
    logic                  burst_done;
    logic [COUNT_BITS-1:0] burst_count;

    modport master (
        output signal, on,
        input  pulse_valid, pulse_width, pulse_error, burst_done, burst_count
    );

    modport slave (
        input  signal, on,
        output pulse_valid, pulse_width, pulse_error, burst_done, burst_count
    );
endinterface

// File: rtl/pulse_train_receiver.sv
// ----------------------------------------------------------------------------
// pulse_train_receiver
//   Samples an asynchronous pulse line through a 2-FF synchronizer, measures
//   each high pulse in clock cycles, classifies it against [MIN_HIGH,MAX_HIGH]
//   and counts legal pulses per burst. A burst is closed once the line has
//   been low for GAP_TIMEOUT consecutive cycles.
//   clock  rising-edge clock
//   reset  asynchronous, active-high; clears all state and outputs
//   bus    pulse_train_receiver_if.slave (signal/on in, results out)
//   All strobes are registered and mutually exclusive; pulse_width and
//   burst_count only change together with their strobe.
// ----------------------------------------------------------------------------
module pulse_train_receiver #(
    parameter int WIDTH_BITS  = 8,
    parameter int COUNT_BITS  = 4,
    parameter int MIN_HIGH    = 2,
    parameter int MAX_HIGH    = 20,
    parameter int GAP_TIMEOUT = 40
) (
    input  logic                  clock,
    input  logic                  reset,
    pulse_train_receiver_if.slave bus
);
    localparam int GAP_BITS = $clog2(GAP_TIMEOUT + 1);

    localparam logic [WIDTH_BITS-1:0] WIDTH_ZERO = {WIDTH_BITS{1'b0}};
    localparam logic [WIDTH_BITS-1:0] WIDTH_ONE  = WIDTH_BITS'(32'd1);
    localparam logic [WIDTH_BITS-1:0] WIDTH_SAT  = {WIDTH_BITS{1'b1}};
    localparam logic [WIDTH_BITS-1:0] WIDTH_MIN  = WIDTH_BITS'(MIN_HIGH);
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX  = WIDTH_BITS'(MAX_HIGH);
    localparam logic [COUNT_BITS-1:0] COUNT_ZERO = {COUNT_BITS{1'b0}};
    localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(32'd1);
    localparam logic [COUNT_BITS-1:0] COUNT_SAT  = {COUNT_BITS{1'b1}};
    localparam logic [GAP_BITS-1:0]   GAP_ZERO   = {GAP_BITS{1'b0}};
    localparam logic [GAP_BITS-1:0]   GAP_ONE    = GAP_BITS'(32'd1);
    localparam logic [GAP_BITS-1:0]   GAP_LAST   = GAP_BITS'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Input path
    logic       sync1_r;
    logic       sync2_r;        // synchronized line (s_sync)
    logic       prev_r;         // s_sync delayed one cycle
    logic [1:0] fill_r;         // marks when sync2_r holds a real post-reset sample
    logic       armed_r;        // line has been seen low since reset
    logic       rise_s;
    logic       fall_s;

    // FSM and counters
    state_t                state_r,  state_s;
    logic [WIDTH_BITS-1:0] width_r,  width_s;
    logic [GAP_BITS-1:0]   gap_r,    gap_s;
    logic [COUNT_BITS-1:0] pcnt_r,   pcnt_s;

    // Registered outputs
    logic                  pulse_valid_r, pulse_valid_s;
    logic                  pulse_error_r, pulse_error_s;
    logic                  burst_done_r,  burst_done_s;
    logic [WIDTH_BITS-1:0] pulse_width_r, pulse_width_s;
    logic [COUNT_BITS-1:0] burst_count_r, burst_count_s;

    assign rise_s = sync2_r & ~prev_r;
    assign fall_s = ~sync2_r & prev_r;

    // Synchronizer, edge history and post-reset arming.
    // A line that is already high when reset releases looks like a rise
    // (the flops restart at 0), so rises are ignored until a genuine low
    // sample has passed through the synchronizer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            fill_r  <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= bus.signal;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            fill_r  <= {fill_r[0], 1'b1};
            armed_r <= armed_r | (fill_r[1] & ~sync2_r);
        end
    end

    // Next-state, counter and strobe decision logic.
    always_comb begin
        state_s       = state_r;
        width_s       = width_r;
        gap_s         = gap_r;
        pcnt_s        = pcnt_r;
        pulse_valid_s = 1'b0;
        pulse_error_s = 1'b0;
        burst_done_s  = 1'b0;
        pulse_width_s = pulse_width_r;
        burst_count_s = burst_count_r;

        if (!bus.on) begin
            // Disabled: abandon any pulse or burst in progress silently.
            state_s = ST_IDLE;
            width_s = WIDTH_ZERO;
            gap_s   = GAP_ZERO;
            pcnt_s  = COUNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pcnt_s = COUNT_ZERO;
                    gap_s  = GAP_ZERO;
                    if (rise_s && armed_r) begin
                        state_s = ST_HIGH;
                        width_s = WIDTH_ONE;
                    end else begin
                        width_s = WIDTH_ZERO;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        pulse_width_s = width_r;
                        if ((width_r >= WIDTH_MIN) && (width_r <= WIDTH_MAX)) begin
                            pulse_valid_s = 1'b1;
                            if (pcnt_r != COUNT_SAT) begin
                                pcnt_s = pcnt_r + COUNT_ONE;
                            end else begin
                                pcnt_s = pcnt_r;
                            end
                        end else begin
                            pulse_error_s = 1'b1;
                        end
                        state_s = ST_GAP;
                        gap_s   = GAP_ONE;
                    end else if (width_r != WIDTH_SAT) begin
                        width_s = width_r + WIDTH_ONE;
                    end else begin
                        // Stuck-high line: hold at saturation until the fall.
                        width_s = width_r;
                    end
                end
                ST_GAP: begin
                    if (rise_s) begin
                        // A new pulse beats the timeout in the same cycle.
                        state_s = ST_HIGH;
                        width_s = WIDTH_ONE;
                        gap_s   = GAP_ZERO;
                    end else if (gap_r >= GAP_LAST) begin
                        burst_done_s  = 1'b1;
                        burst_count_s = pcnt_r;
                        pcnt_s        = COUNT_ZERO;
                        gap_s         = GAP_ZERO;
                        state_s       = ST_IDLE;
                    end else begin
                        gap_s = gap_r + GAP_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    width_s = WIDTH_ZERO;
                    gap_s   = GAP_ZERO;
                    pcnt_s  = COUNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            width_r       <= WIDTH_ZERO;
            gap_r         <= GAP_ZERO;
            pcnt_r        <= COUNT_ZERO;
            pulse_valid_r <= 1'b0;
            pulse_error_r <= 1'b0;
            burst_done_r  <= 1'b0;
            pulse_width_r <= WIDTH_ZERO;
            burst_count_r <= COUNT_ZERO;
        end else begin
            state_r       <= state_s;
            width_r       <= width_s;
            gap_r         <= gap_s;
            pcnt_r        <= pcnt_s;
            pulse_valid_r <= pulse_valid_s;
            pulse_error_r <= pulse_error_s;
            burst_done_r  <= burst_done_s;
            pulse_width_r <= pulse_width_s;
            burst_count_r <= burst_count_s;
        end
    end

    assign bus.pulse_valid = pulse_valid_r;
    assign bus.pulse_error = pulse_error_r;
    assign bus.burst_done  = burst_done_r;
    assign bus.pulse_width = pulse_width_r;
    assign bus.burst_count = burst_count_r;

endmodule
